// File: rtl/fact_pkg.sv
// Shared definitions for the factorial accelerator bus interface:
// FSM state encoding, register offsets and STATUS bit positions.
package fact_pkg;

  // Default operand width handed to the factorial core
  localparam int FACT_N_WIDTH_DEF = 4;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } fact_state_t;

  // Word offsets (address bits [3:2])
  localparam logic [1:0] FACT_N      = 2'd0;
  localparam logic [1:0] FACT_GO     = 2'd1;
  localparam logic [1:0] FACT_STATUS = 2'd2;
  localparam logic [1:0] FACT_RESULT = 2'd3;

  // STATUS register bit positions
  localparam int STAT_DONE = 0;
  localparam int STAT_ERR  = 1;
  localparam int STAT_BUSY = 2;
  localparam int STAT_TMO  = 3;

  // Assemble the 4-bit STATUS field from its flags
  function automatic logic [3:0] pack_status(input logic tmo, input logic busy,
                                             input logic err, input logic done);
    logic [3:0] s;
    s            = 4'b0;
    s[STAT_TMO]  = tmo;
    s[STAT_BUSY] = busy;
    s[STAT_ERR]  = err;
    s[STAT_DONE] = done;
    return s;
  endfunction

endpackage

// File: rtl/fact_wdog.sv
// Watchdog: loadable up-counter with a terminal-count flag. The flag is
// raised while the count sits at TERMINAL-1, i.e. during the TERMINAL-th
// enabled cycle after a load.
module fact_wdog #(
  parameter int TERMINAL = 64,
  parameter int WIDTH    = $clog2(TERMINAL)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(TERMINAL - 1);

  logic [WIDTH-1:0] count_reg;

  // Count enabled cycles; load clears, reset clears
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = (count_reg == TERM_VAL);

endmodule

// File: rtl/fact_mmio_if.sv
// MIPS data-bus interface for the factorial accelerator: N/GO/STATUS/RESULT
// register file, one-cycle start pulse, sticky outcome flags and a watchdog
// that ends a run whose core never answers.
module fact_mmio_if
  import fact_pkg::*;
#(
  parameter int N_WIDTH        = FACT_N_WIDTH_DEF,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [1:0]            a,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  core_go,
  output logic [N_WIDTH-1:0]    core_n,
  input  logic                  core_done,
  input  logic                  core_err,
  input  logic [DATA_WIDTH-1:0] core_result
);

  fact_state_t state_reg, state_next;

  logic [N_WIDTH-1:0]    n_reg;
  logic                  go_reg;
  logic                  done_reg;
  logic                  err_reg;
  logic                  tmo_reg;
  logic [DATA_WIDTH-1:0] result_reg;

  logic busy;
  logic start;
  logic wdog_tc;
  logic unused_wd;

  // Only the low N_WIDTH bits of write data carry meaning
  assign unused_wd = &{1'b0, wd[DATA_WIDTH-1:N_WIDTH]};

  // START counts as busy so the operand cannot change under the core
  assign busy  = (state_reg == ST_START) || (state_reg == ST_WAIT);
  assign start = we && (a == FACT_GO) && wd[0] &&
                 ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  assign core_n = n_reg;

  fact_wdog #(
    .TERMINAL(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk (clk),
    .rst (rst),
    .load(state_reg == ST_START),
    .en  (state_reg == ST_WAIT),
    .tc  (wdog_tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and start pulse
  always_comb begin
    state_next = state_reg;
    core_go    = 1'b0;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_START;
      ST_START: begin
        core_go    = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT:  if (core_err || core_done || wdog_tc) state_next = ST_DONE;
      ST_DONE:  if (start) state_next = ST_START;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Register file writes and outcome capture
  always_ff @(posedge clk) begin
    if (rst) begin
      n_reg      <= '0;
      go_reg     <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      tmo_reg    <= 1'b0;
      result_reg <= '0;
    end else begin
      if (we && !busy) begin
        case (a)
          FACT_N:  n_reg  <= wd[N_WIDTH-1:0];
          FACT_GO: go_reg <= wd[0];
          default: ;
        endcase
      end
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          // Clear outcome on the edge into START so START already reads clean
          if (start) begin
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            tmo_reg    <= 1'b0;
            result_reg <= '0;
          end
        end
        ST_WAIT: begin
          if (core_err) begin
            err_reg    <= 1'b1;
            result_reg <= '0;
            go_reg     <= 1'b0;
          end else if (core_done) begin
            done_reg   <= 1'b1;
            result_reg <= core_result;
            go_reg     <= 1'b0;
          end else if (wdog_tc) begin
            tmo_reg    <= 1'b1;
            err_reg    <= 1'b1;
            go_reg     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Read mux, zero-extended
  always_comb begin
    rd = '0;
    case (a)
      FACT_N:      rd = DATA_WIDTH'(n_reg);
      FACT_GO:     rd = DATA_WIDTH'(go_reg);
      FACT_STATUS: rd = DATA_WIDTH'(pack_status(tmo_reg, busy, err_reg, done_reg));
      default:     rd = result_reg;
    endcase
  end

endmodule

// File: tb/tb_fact_mmio_if.sv
// Directed bench for fact_mmio_if: the bench plays CPU and factorial core,
// inputs change on the falling edge and outputs are sampled there too.
module tb_fact_mmio_if;

  localparam int NW = 4;
  localparam int DW = 32;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [1:0]    a;
  logic [DW-1:0] wd;
  logic [DW-1:0] rd;
  logic          core_go;
  logic [NW-1:0] core_n;
  logic          core_done;
  logic          core_err;
  logic [DW-1:0] core_result;

  int checks_total  = 0;
  int checks_passed = 0;

  fact_mmio_if #(
    .N_WIDTH(NW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .a          (a),
    .wd         (wd),
    .rd         (rd),
    .core_go    (core_go),
    .core_n     (core_n),
    .core_done  (core_done),
    .core_err   (core_err),
    .core_result(core_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
      $display("check %-18s got 0x%08h exp 0x%08h ok", tag, got, exp);
    end else begin
      $display("FAIL %-18s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  // One bus write; returns on the falling edge right after the write edge
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1;
    a  = addr;
    wd = data;
    @(negedge clk);
    we = 1'b0;
    wd = '0;
  endtask

  // Combinational read at the current falling edge
  task automatic bus_read(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    a = addr;
    #1;
    chk(tag, rd, exp);
  endtask

  // Core answers during the next cycle (one-cycle pulse)
  task automatic core_reply(input logic done, input logic err, input logic [31:0] res);
    core_done   = done;
    core_err    = err;
    core_result = res;
    @(negedge clk);
    core_done   = 1'b0;
    core_err    = 1'b0;
    core_result = '0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; a = 2'd0; wd = '0;
    core_done = 1'b0; core_err = 1'b0; core_result = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_core_go", 32'(core_go), 32'd0);
    chk("rst_core_n", 32'(core_n), 32'd0);
    bus_read("rst_n", 2'd0, 32'd0);
    bus_read("rst_go", 2'd1, 32'd0);
    bus_read("rst_status", 2'd2, 32'd0);
    bus_read("rst_result", 2'd3, 32'd0);

    // 5! = 120, core answers in the 6th cycle after the pulse
    bus_write(2'd0, 32'd5);
    bus_read("n5", 2'd0, 32'd5);
    chk("core_n5", 32'(core_n), 32'd5);
    bus_write(2'd1, 32'd1);
    chk("go_pulse_hi", 32'(core_go), 32'd1);
    bus_read("start_status", 2'd2, 32'h4);
    @(negedge clk);
    chk("go_pulse_lo", 32'(core_go), 32'd0);
    bus_read("busy_status", 2'd2, 32'h4);
    repeat (4) @(negedge clk);
    core_reply(1'b1, 1'b0, 32'd120);
    bus_read("f5_status", 2'd2, 32'h1);
    bus_read("f5_result", 2'd3, 32'h78);
    bus_read("f5_go_clr", 2'd1, 32'd0);

    // 0! = 1, done flag cleared at restart
    bus_write(2'd0, 32'd0);
    bus_write(2'd1, 32'd1);
    bus_read("f0_clr_status", 2'd2, 32'h4);
    bus_read("f0_clr_result", 2'd3, 32'h0);
    @(negedge clk);
    core_reply(1'b1, 1'b0, 32'd1);
    bus_read("f0_status", 2'd2, 32'h1);
    bus_read("f0_result", 2'd3, 32'h1);

    // 13 overflows: error with garbage product
    bus_write(2'd0, 32'd13);
    bus_write(2'd1, 32'd1);
    repeat (2) @(negedge clk);
    core_reply(1'b0, 1'b1, 32'hDEAD);
    bus_read("err_status", 2'd2, 32'h2);
    bus_read("err_result", 2'd3, 32'h0);

    // done and err in the same cycle: err wins
    bus_write(2'd1, 32'd1);
    @(negedge clk);
    core_reply(1'b1, 1'b1, 32'd55);
    bus_read("both_status", 2'd2, 32'h2);
    bus_read("both_result", 2'd3, 32'h0);

    // Writes while busy are ignored
    bus_write(2'd0, 32'd5);
    bus_write(2'd1, 32'd1);
    @(negedge clk);
    bus_write(2'd0, 32'd7);
    bus_read("busy_n_hold", 2'd0, 32'd5);
    chk("busy_core_n", 32'(core_n), 32'd5);
    bus_write(2'd1, 32'd1);
    chk("busy_no_go", 32'(core_go), 32'd0);
    bus_read("busy2_status", 2'd2, 32'h4);
    core_reply(1'b0, 1'b1, 32'd0);
    bus_read("busy_err_status", 2'd2, 32'h2);

    // Restart from DONE clears err; core then never answers
    bus_write(2'd1, 32'd1);
    chk("restart_go", 32'(core_go), 32'd1);
    bus_read("restart_status", 2'd2, 32'h4);
    repeat (TO) @(negedge clk);
    bus_read("tmo_edge_status", 2'd2, 32'h4);
    @(negedge clk);
    bus_read("tmo_status", 2'd2, 32'hA);
    bus_read("tmo_result", 2'd3, 32'h0);
    bus_read("tmo_go", 2'd1, 32'd0);

    // Reset during WAIT aborts, and a late done is ignored
    bus_write(2'd0, 32'd3);
    bus_write(2'd1, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    core_done = 1'b1;
    core_result = 32'd6;
    @(negedge clk);
    rst = 1'b0;
    core_done = 1'b0;
    core_result = '0;
    chk("mid_rst_core_go", 32'(core_go), 32'd0);
    chk("mid_rst_core_n", 32'(core_n), 32'd0);
    bus_read("mid_rst_status", 2'd2, 32'h0);
    bus_read("mid_rst_result", 2'd3, 32'h0);
    bus_read("mid_rst_n", 2'd0, 32'h0);
    @(negedge clk);
    core_reply(1'b1, 1'b0, 32'd6);
    bus_read("late_done_status", 2'd2, 32'h0);
    bus_read("late_done_result", 2'd3, 32'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/fact_mmio_if.md
Name: fact_mmio_if

Overview:
Memory-mapped bus interface between the MIPS core data bus and the factorial accelerator core. It decodes CPU word writes and reads into N, GO, STATUS and RESULT registers, and drives a single-cycle start pulse into the factorial core. It captures the core's done/error outcome into sticky status bits and latches the product. A watchdog flags a core that never completes.

Parameters:
N_WIDTH, 4, width of operand n passed to the factorial core
DATA_WIDTH, 32, bus and result width
TIMEOUT_CYCLES, 64, max cycles in WAIT before timeout error (>=2)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  synchronous active-high reset
we  in  1  write enable from CPU address decoder (block selected)
a  in  2  word address [3:2]: 0=N, 1=GO, 2=STATUS, 3=RESULT
wd  in  DATA_WIDTH  write data
rd  out  DATA_WIDTH  read data, combinational on a
core_go  out  1  one-cycle start pulse to factorial core
core_n  out  N_WIDTH  operand to core, held stable while busy
core_done  in  1  core completion pulse/level
core_err  in  1  core overflow error (n > 12)
core_result  in  DATA_WIDTH  core product, valid when core_done=1

Behaviour:
- Clock clk; reset rst is synchronous, active-high.
- Reset: state=IDLE, n_reg=0, go_reg=0, done=0, err=0, tmo=0, result_reg=0, wdog=0, core_go=0. Reset mid-operation aborts to IDLE; core_done/core_err are ignored in the reset cycle.
- Register map, read values (zero-extended):
  - a=0: n_reg.
  - a=1: go_reg bit0.
  - a=2: {28'b0, tmo, busy, err, done} (bit3..bit0).
  - a=3: result_reg.
- Write a=0: n_reg <= wd[N_WIDTH-1:0]. Ignored while busy.
- Write a=2 or a=3: ignored (read-only).
- Write a=1: go_reg <= wd[0]. Ignored while busy. wd[0]=1 in IDLE or DONE triggers a start.
- core_n = n_reg at all times.
- FSM states and transitions:
  - IDLE: busy=0. A start moves to START.
  - START: exactly one cycle. core_go=1. On entry, clear done, err and tmo and zero result_reg. wdog<=0. Next state WAIT.
  - WAIT: busy=1. wdog increments each cycle.
    - core_err=1: err<=1, result_reg<=0, go to DONE.
    - else core_done=1: result_reg<=core_result, done<=1, go to DONE.
    - else wdog==TIMEOUT_CYCLES-1: tmo<=1, err<=1, go to DONE.
    - core_err has priority over core_done in the same cycle.
  - DONE: busy=0. Hold sticky bits. A start moves to START (re-run with current n_reg).
- go_reg auto-clears to 0 on entry to DONE.
- Latency: from the GO write edge, core_go is high the next cycle. Result is visible on rd the cycle after core_done is sampled.
- Simultaneous GO write and N write cannot occur (single write port). Software writes N, then GO.

Decomposition:
- Shared package fact_pkg: state encoding (IDLE/START/WAIT/DONE, 2 bits), register offsets (FACT_N=2'd0, FACT_GO=2'd1, FACT_STATUS=2'd2, FACT_RESULT=2'd3), status bit indices, N_WIDTH default.
- One natural sub-module: fact_wdog, a loadable up-counter with terminal-count flag, used for the timeout.
- Read mux and register file stay inline.

Test Plan:
- Write N=5, GO=1; core model returns 120 after 6 cycles -> core_go high exactly 1 cycle, core_n=5, STATUS=0x4 while busy, then STATUS=0x1, RESULT=0x78, GO reads 0.
- N=0, GO=1; core returns 1 -> RESULT=0x1, STATUS=0x1.
- N=13, GO=1; core asserts core_err -> STATUS=0x2, RESULT=0. Same-cycle core_done+core_err -> STATUS=0x2.
- While busy, write N=7 and GO=1 -> N still reads 5, no second core_go pulse. After DONE, GO=1 restarts and clears done/err.
- Core stub never responds -> after TIMEOUT_CYCLES (64) WAIT cycles, STATUS=0xA, RESULT=0, state DONE.
- Assert rst for one cycle during WAIT -> next cycle all outputs zero, STATUS=0. A later core_done is ignored (STATUS stays 0).
